capture_fifo: RTL and testbench
===============================

// Module: capture_fifo
// PURPOSE
//  Sample buffer directly downstream of channel_input: accepts 32-bit sample words on its save strobe and holds them until the host drains them.
//  Drives o_full back to channel_input as fifo_full, which gates further saves.
//  Read side is first-word-fall-through (FWFT): o_data is valid whenever o_available is high.
//  Adds an occupancy count, an almost-full flag and overflow/drop accounting.
// PARAMETERS
//  DATA_W     32  sample word width
//  DEPTH      16  total entries (power of two, >=4); ADDR_W = $clog2(DEPTH)
//  AFULL_LVL  12  o_almost_full asserts when o_count >= AFULL_LVL (1..DEPTH)
//  DROP_W     16  width of the dropped-word counter
// PORTS
//  i_clk          in   1          sole clock; all logic on posedge
//  i_rst          in   1          synchronous reset, active-high
//  i_clear        in   1          synchronous flush (capture re-arm)
//  i_wr           in   1          write strobe (channel_input save)
//  i_wr_data      in   DATA_W     write word (channel_input data)
//  o_full         out  1          count == DEPTH
//  o_almost_full  out  1          count >= AFULL_LVL
//  i_rd           in   1          pop request; honoured only while o_available=1
//  o_data         out  DATA_W     head word, valid while o_available=1
//  o_available    out  1          FIFO non-empty (head word presented)
//  o_count        out  ADDR_W+1   entries held, 0..DEPTH
//  o_overflow     out  1          sticky: a write was rejected
//  o_dropped      out  DROP_W     rejected writes, saturating
// BEHAVIOUR
//  Reset: outputs as follows:
//   - o_available=0, o_full=0, o_almost_full=0, o_count=0, o_overflow=0, o_dropped=0, o_data=0.
//   - Pointers reset to 0.
//  Priority per cycle: i_rst > i_clear > rd/wr. i_clear has the same effect as reset on every register except RAM contents.
//  Accept rules, evaluated on pre-edge state:
//   - wr_ok = i_wr & ~o_full; rd_ok = i_rd & o_available.
//   - Write while full is rejected even if rd_ok fires in the same cycle (o_full is a registered, conservative flag).
//   - A rejected write sets o_overflow and increments o_dropped, which saturates at all-ones.
//   - i_rd while empty is ignored; no underflow, no state change.
//  Storage and pointers:
//   - Write/read pointers are ADDR_W+1 bits and wrap modulo 2*DEPTH.
//   - full  = ptr MSBs differ and lower bits equal.
//   - empty = pointers equal.
//  Count: o_count <= o_count + wr_ok - rd_ok. rd_ok & wr_ok together leave the count unchanged.
//  Flags: o_full, o_almost_full and o_available are registered and derived from the next count, so they are valid in the same cycle as o_count.
//  Latency:
//   - Word written at edge N: o_available=1 and o_data = that word after edge N (visible in cycle N+1) when the FIFO was empty.
//   - This uses a bypass into the head register when empty, or when the pop in that cycle drains the last entry.
//  Pop: on rd_ok at edge N, o_data shows the next word after edge N, or o_available drops when the FIFO empties.
//  Head register: a registered output stage. The RAM is read-ahead (address = read pointer + 1 on pop) so the head refills without a bubble.
//  Ordering: strict FIFO order. No word is duplicated or lost except rejected writes.
//  Clear/reset mid-burst: contents are discarded and o_available falls next cycle. A simultaneous i_wr is dropped and not counted as overflow.
//  No combinational path from i_rd or i_wr to any output.
// STRUCTURE
//  Shared package la_pkg:
//   - SAMPLE_W = 32.
//   - Default CAPTURE_FIFO_DEPTH.
//   - capture_fifo status struct {count, afull, overflow, dropped} for the host register map.
//  Sub-module capture_fifo_ram: simple dual-port RAM (one write port, one registered read port), DEPTH x DATA_W, no reset. Inferable as block RAM.
//  Top level holds pointers, count, flags, bypass/head logic and drop counter.
// TESTING
//  1. Reset, then write A,B,C on three consecutive cycles:
//     - o_available=1 with o_data=A one cycle after A is written.
//     - Pop 3 times back to back -> A,B,C in order.
//     - o_count 3 -> 0, o_available=0 after the third pop.
//  2. Write 16 words (DEPTH=16):
//     - o_almost_full rises when count reaches 12.
//     - o_full rises when count reaches 16.
//     - 3 more writes -> o_dropped=3 and o_overflow=1; contents unchanged.
//  3. At count 5, assert i_wr & i_rd together for 10 cycles -> o_count stays 5, and the output stream is the 5 old words then the new words in order.
//  4. Full FIFO with i_wr & i_rd in the same cycle -> the read pops, the write is rejected, o_dropped increments, count becomes 15.
//  5. At count 9, assert i_clear together with i_wr:
//     - Next cycle o_count=0, o_available=0, o_overflow=0, o_dropped=0.
//     - The next single write appears at the head one cycle later.
//  6. Pointer wrap: run 3*DEPTH+5 words through with random rd/wr gaps against a scoreboard -> no loss or reordering.
//     Also: i_rd while empty -> no state change.

Source files
------------

// File: rtl/la_pkg.sv
// Shared logic-analyser definitions: sample width, capture FIFO defaults and
// the status word the host register map exposes for the capture FIFO.
package la_pkg;

    localparam int SAMPLE_W            = 32;
    localparam int CAPTURE_FIFO_DEPTH  = 16;
    localparam int CAPTURE_FIFO_AFULL  = 12;
    localparam int CAPTURE_FIFO_DROP_W = 16;

    typedef struct packed {
        logic [$clog2(CAPTURE_FIFO_DEPTH):0] count;
        logic                                afull;
        logic                                overflow;
        logic [CAPTURE_FIFO_DROP_W-1:0]      dropped;
    } capture_fifo_status_t;

endpackage

// File: rtl/capture_fifo_if.sv
// Host-facing bundle of the capture FIFO: write side from channel_input,
// FWFT read side and status outputs towards the host.
interface capture_fifo_if
    import la_pkg::*;
#(
    parameter int DATA_W = SAMPLE_W,
    parameter int DEPTH  = CAPTURE_FIFO_DEPTH,
    parameter int DROP_W = CAPTURE_FIFO_DROP_W
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              i_clear;
    logic              i_wr;
    logic [DATA_W-1:0] i_wr_data;
    logic              i_rd;
    logic              o_full;
    logic              o_almost_full;
    logic [DATA_W-1:0] o_data;
    logic              o_available;
    logic [ADDR_W:0]   o_count;
    logic              o_overflow;
    logic [DROP_W-1:0] o_dropped;

    modport master (
        output i_clear, i_wr, i_wr_data, i_rd,
        input  o_full, o_almost_full, o_data, o_available, o_count, o_overflow, o_dropped
    );

    modport slave (
        input  i_clear, i_wr, i_wr_data, i_rd,
        output o_full, o_almost_full, o_data, o_available, o_count, o_overflow, o_dropped
    );

endinterface

// File: rtl/capture_fifo_ram.sv
// Simple dual-port sample store: one write port, one registered read port,
// no reset so it maps onto block RAM.
module capture_fifo_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/capture_fifo.sv
// First-word-fall-through capture buffer with occupancy, almost-full and
// saturating drop accounting; the head word comes from RAM or a write bypass.
module capture_fifo
    import la_pkg::*;
#(
    parameter int DATA_W    = SAMPLE_W,
    parameter int DEPTH     = CAPTURE_FIFO_DEPTH,
    parameter int AFULL_LVL = CAPTURE_FIFO_AFULL,
    parameter int DROP_W    = CAPTURE_FIFO_DROP_W
) (
    input  logic           i_clk,
    input  logic           i_rst,
    capture_fifo_if.slave  bus
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [ADDR_W:0]   r_wrPtr;
    logic [ADDR_W:0]   r_rdPtr;
    logic [ADDR_W:0]   r_count;
    logic              r_full;
    logic              r_almostFull;
    logic              r_available;
    logic              r_overflow;
    logic [DROP_W-1:0] r_dropped;
    logic              r_bypSel;
    logic [DATA_W-1:0] r_bypData;

    logic              w_flush;
    logic              w_wrOk;
    logic              w_rdOk;
    logic              w_reject;
    logic              w_ptrEmpty;
    logic              w_bypass;
    logic [ADDR_W:0]   w_rdPtrInc;
    logic [ADDR_W:0]   w_nextCount;
    logic [ADDR_W-1:0] w_rdAddr;
    logic [DATA_W-1:0] w_ramData;

    assign w_flush     = i_rst | bus.i_clear;
    assign w_wrOk      = bus.i_wr & ~r_full & ~w_flush;
    assign w_rdOk      = bus.i_rd & r_available;
    assign w_reject    = bus.i_wr & r_full;
    assign w_ptrEmpty  = (r_wrPtr == r_rdPtr);
    assign w_rdPtrInc  = r_rdPtr + (ADDR_W+1)'(1);
    assign w_nextCount = r_count + (ADDR_W+1)'(w_wrOk) - (ADDR_W+1)'(w_rdOk);

    // The RAM reads the slot the head will occupy after this edge; when that
    // slot is being written on this very edge the RAM would return stale data.
    assign w_bypass = w_wrOk & (w_ptrEmpty | (w_rdOk & (w_rdPtrInc == r_wrPtr)));
    assign w_rdAddr = w_rdOk ? w_rdPtrInc[ADDR_W-1:0] : r_rdPtr[ADDR_W-1:0];

    capture_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_wrOk),
        .i_waddr (r_wrPtr[ADDR_W-1:0]),
        .i_wdata (bus.i_wr_data),
        .i_raddr (w_rdAddr),
        .o_rdata (w_ramData)
    );

    // Flags follow the next count so they line up with o_count.
    always_ff @(posedge i_clk) begin
        if (w_flush) begin
            r_wrPtr      <= '0;
            r_rdPtr      <= '0;
            r_count      <= '0;
            r_full       <= 1'b0;
            r_almostFull <= 1'b0;
            r_available  <= 1'b0;
            r_overflow   <= 1'b0;
            r_dropped    <= '0;
            r_bypSel     <= 1'b1;
            r_bypData    <= '0;
        end else begin
            if (w_wrOk) begin
                r_wrPtr <= r_wrPtr + (ADDR_W+1)'(1);
            end
            if (w_rdOk) begin
                r_rdPtr <= w_rdPtrInc;
            end
            r_count      <= w_nextCount;
            r_full       <= (w_nextCount == (ADDR_W+1)'(DEPTH));
            r_almostFull <= (w_nextCount >= (ADDR_W+1)'(AFULL_LVL));
            r_available  <= (w_nextCount != '0);
            if (w_reject) begin
                r_overflow <= 1'b1;
                if (r_dropped != '1) begin
                    r_dropped <= r_dropped + DROP_W'(1);
                end
            end
            if (w_bypass) begin
                r_bypSel  <= 1'b1;
                r_bypData <= bus.i_wr_data;
            end else if (w_rdOk) begin
                r_bypSel  <= 1'b0;
            end
        end
    end

    assign bus.o_data        = r_bypSel ? r_bypData : w_ramData;
    assign bus.o_available   = r_available;
    assign bus.o_full        = r_full;
    assign bus.o_almost_full = r_almostFull;
    assign bus.o_count       = r_count;
    assign bus.o_overflow    = r_overflow;
    assign bus.o_dropped     = r_dropped;

endmodule

// File: tb/tb_capture_fifo.sv
// Scoreboard bench for capture_fifo: a queue model tracks accepted words and
// status, while a negedge monitor compares every DUT output against it.
module tb_capture_fifo;

    localparam int DATA_W    = 32;
    localparam int DEPTH     = 16;
    localparam int AFULL_LVL = 12;
    localparam int DROP_W    = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    capture_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DROP_W(DROP_W)) bus ();

    capture_fifo #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .AFULL_LVL (AFULL_LVL),
        .DROP_W    (DROP_W)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int                testsRun    = 0;
    int                testsFailed = 0;
    logic [DATA_W-1:0] expQ [$];
    bit                mOvf;
    int                mDrop;
    bit                monEn = 1'b0;
    int                mSize;

    task automatic checkOutput(input string name, input longint unsigned act,
                               input longint unsigned exp);
        testsRun++;
        if (act != exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives one edge worth of inputs, then returns 1 time unit after that edge.
    task automatic applyStimulus(input bit wr, input logic [DATA_W-1:0] data,
                                 input bit rd, input bit clr);
        bus.i_wr      = wr;
        bus.i_wr_data = data;
        bus.i_rd      = rd;
        bus.i_clear   = clr;
        @(posedge clk);
        #1;
        bus.i_wr      = 1'b0;
        bus.i_wr_data = '0;
        bus.i_rd      = 1'b0;
        bus.i_clear   = 1'b0;
    endtask

    // Reference model: a plain queue of accepted words plus drop bookkeeping,
    // decided on the occupancy seen before the edge.
    always @(posedge clk) begin
        if (rst || bus.i_clear) begin
            expQ.delete();
            mOvf  = 1'b0;
            mDrop = 0;
        end else begin
            mSize = expQ.size();
            if (bus.i_rd && mSize > 0) begin
                void'(expQ.pop_front());
            end
            if (bus.i_wr) begin
                if (mSize < DEPTH) begin
                    expQ.push_back(bus.i_wr_data);
                end else begin
                    mOvf = 1'b1;
                    if (mDrop < (1 << DROP_W) - 1) mDrop++;
                end
            end
        end
    end

    // Monitor: every cycle, away from the edge, compare status and head word.
    always @(negedge clk) begin
        if (monEn) begin
            checkOutput("count",     bus.o_count,       expQ.size());
            checkOutput("available", bus.o_available,   expQ.size() > 0);
            checkOutput("full",      bus.o_full,        expQ.size() == DEPTH);
            checkOutput("afull",     bus.o_almost_full, expQ.size() >= AFULL_LVL);
            checkOutput("overflow",  bus.o_overflow,    mOvf);
            checkOutput("dropped",   bus.o_dropped,     mDrop);
            if (expQ.size() > 0) begin
                checkOutput("head_data", bus.o_data, expQ[0]);
            end
        end
    end

    initial begin
        rst           = 1'b1;
        bus.i_wr      = 1'b0;
        bus.i_wr_data = '0;
        bus.i_rd      = 1'b0;
        bus.i_clear   = 1'b0;
        @(posedge clk);
        #1;
        monEn = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rst_data",  bus.o_data, 0);
        checkOutput("rst_avail", bus.o_available, 0);
        checkOutput("rst_count", bus.o_count, 0);

        // Three words, each visible at the head one cycle after its write.
        applyStimulus(1'b1, 32'hAAAA_0001, 1'b0, 1'b0);
        checkOutput("t1_headA", bus.o_data, 32'hAAAA_0001);
        checkOutput("t1_availA", bus.o_available, 1);
        applyStimulus(1'b1, 32'hBBBB_0002, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hCCCC_0003, 1'b0, 1'b0);
        checkOutput("t1_count3", bus.o_count, 3);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("t1_headB", bus.o_data, 32'hBBBB_0002);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("t1_headC", bus.o_data, 32'hCCCC_0003);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("t1_empty", bus.o_available, 0);
        checkOutput("t1_count0", bus.o_count, 0);

        // Fill to full, watching the almost-full and full thresholds.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 32'h1000_0000 + i, 1'b0, 1'b0);
            if (i == AFULL_LVL - 2) checkOutput("t2_afull_lo", bus.o_almost_full, 0);
            if (i == AFULL_LVL - 1) checkOutput("t2_afull_hi", bus.o_almost_full, 1);
            if (i == DEPTH - 2)     checkOutput("t2_full_lo", bus.o_full, 0);
        end
        checkOutput("t2_full_hi", bus.o_full, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'hDEAD_0000 + i, 1'b0, 1'b0);
        checkOutput("t2_dropped", bus.o_dropped, 3);
        checkOutput("t2_overflow", bus.o_overflow, 1);
        checkOutput("t2_head", bus.o_data, 32'h1000_0000);

        // Full with simultaneous read and write: only the read is honoured.
        applyStimulus(1'b1, 32'hDEAD_0010, 1'b1, 1'b0);
        checkOutput("t4_count", bus.o_count, DEPTH - 1);
        checkOutput("t4_dropped", bus.o_dropped, 4);
        checkOutput("t4_head", bus.o_data, 32'h1000_0001);
        while (bus.o_available) applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Clear with a concurrent write at count 9.
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 32'h2000_0000 + i, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h2BAD_BAD0, 1'b0, 1'b1);
        checkOutput("t5_count", bus.o_count, 0);
        checkOutput("t5_avail", bus.o_available, 0);
        checkOutput("t5_overflow", bus.o_overflow, 0);
        checkOutput("t5_dropped", bus.o_dropped, 0);
        applyStimulus(1'b1, 32'h2000_00FF, 1'b0, 1'b0);
        checkOutput("t5_head", bus.o_data, 32'h2000_00FF);
        checkOutput("t5_avail1", bus.o_available, 1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Read while empty is ignored.
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("empty_rd_count", bus.o_count, 0);
        checkOutput("empty_rd_avail", bus.o_available, 0);

        // Steady read+write at count 5.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'h3000_0000 + i, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 32'h3100_0000 + i, 1'b1, 1'b0);
            checkOutput("t3_count", bus.o_count, 5);
        end
        checkOutput("t3_head", bus.o_data, 32'h3100_0005);
        while (bus.o_available) applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Random traffic, many times around the pointer range.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 99) < 55, $urandom,
                          $urandom_range(0, 99) < 50, 1'b0);
        end
        for (int i = 0; i < DEPTH + 4; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("t6_drained", bus.o_count, 0);

        monEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
